// File: rtl/counter_pkg.sv
// Shared FSM encoding and default widths for the counter controller.
// latency: n/a; backpressure: n/a.
package counter_pkg;

    localparam int COUNT_WIDTH_DEF    = 4;
    localparam int PRESCALE_WIDTH_DEF = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/counter_ctrl_if.sv
// Control/status bundle between a counter controller and its user.
// latency: n/a; backpressure: none, all signals are level/pulse qualified.
interface counter_ctrl_if
    import counter_pkg::*;
#(
    parameter int COUNT_WIDTH    = COUNT_WIDTH_DEF,
    parameter int PRESCALE_WIDTH = PRESCALE_WIDTH_DEF
) ();

    logic                      start_i;
    logic                      stop_i;
    logic                      step_i;
    logic                      clear_i;
    logic                      oneshot_i;
    logic [PRESCALE_WIDTH-1:0] prescale_i;
    logic [COUNT_WIDTH-1:0]    counter_value_i;
    logic                      enable_o;
    logic                      clear_o;
    logic                      busy_o;
    logic                      done_o;

    modport master (
        output start_i, stop_i, step_i, clear_i, oneshot_i, prescale_i, counter_value_i,
        input  enable_o, clear_o, busy_o, done_o
    );

    modport slave (
        input  start_i, stop_i, step_i, clear_i, oneshot_i, prescale_i, counter_value_i,
        output enable_o, clear_o, busy_o, done_o
    );

endinterface

// File: rtl/counter_ctrl_prescaler.sv
// Free-running prescaler that reloads to zero when it reaches the reload value.
// latency: tick is combinational from the count register; backpressure: none.
module counter_ctrl_prescaler #(
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                      clock_i,
    input  logic                      reset_n_i,
    input  logic                      restart,
    input  logic                      run,
    input  logic [PRESCALE_WIDTH-1:0] reload,
    output logic                      tick
);

    logic [PRESCALE_WIDTH-1:0] cnt;

    assign tick = (cnt == reload);

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt <= '0;
        end else if (restart) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/counter_ctrl.sv
// Start/stop/step/oneshot controller generating a prescaled enable for an external counter.
// latency: all outputs registered, one cycle after the deciding edge; backpressure: none.
module counter_ctrl
    import counter_pkg::*;
#(
    parameter int COUNT_WIDTH    = COUNT_WIDTH_DEF,
    parameter int PRESCALE_WIDTH = PRESCALE_WIDTH_DEF
) (
    input  logic           clock_i,
    input  logic           reset_n_i,
    counter_ctrl_if.slave  bus
);

    logic [1:0]                state;
    logic [PRESCALE_WIDTH-1:0] reload;
    logic                      oneshot;
    logic                      enable;
    logic                      clear_pulse;
    logic                      run;
    logic                      restart;
    logic                      tick;
    logic                      wrap;
    logic [PRESCALE_WIDTH-1:0] prescale_in;
    logic [COUNT_WIDTH-1:0]    count_in;

    assign prescale_in = bus.prescale_i;
    assign count_in    = bus.counter_value_i;

    assign run     = (state == ST_RUN);
    assign restart = !bus.clear_i && !bus.stop_i && bus.start_i && !run;
    // The counter is about to wrap on this edge if it is enabled and at all-ones.
    assign wrap    = oneshot && enable && (count_in == {COUNT_WIDTH{1'b1}});

    counter_ctrl_prescaler #(
        .PRESCALE_WIDTH (PRESCALE_WIDTH)
    ) u_prescaler (
        .clock_i   (clock_i),
        .reset_n_i (reset_n_i),
        .restart   (restart),
        .run       (run),
        .reload    (reload),
        .tick      (tick)
    );

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state       <= ST_IDLE;
            reload      <= '0;
            oneshot     <= 1'b0;
            enable      <= 1'b0;
            clear_pulse <= 1'b0;
        end else begin
            clear_pulse <= bus.clear_i;
            enable      <= 1'b0;
            if (bus.clear_i) begin
                state <= ST_IDLE;
            end else if (bus.stop_i) begin
                if (run) begin
                    state <= ST_IDLE;
                end
            end else if (restart) begin
                state   <= ST_RUN;
                reload  <= prescale_in;
                oneshot <= bus.oneshot_i;
            end else if (run) begin
                if (wrap) begin
                    state <= ST_DONE;
                end else begin
                    enable <= tick;
                end
            end else if (bus.step_i && (state == ST_IDLE)) begin
                enable <= 1'b1;
            end
        end
    end

    assign bus.enable_o = enable;
    assign bus.clear_o  = clear_pulse;
    assign bus.busy_o   = (state == ST_RUN);
    assign bus.done_o   = (state == ST_DONE);

endmodule

// File: tb/tb_counter_ctrl.sv
// Randomized and directed bench for counter_ctrl against a countdown-based reference model.
// latency: n/a; backpressure: n/a.
module tb_counter_ctrl;

    logic clock_i   = 1'b0;
    logic reset_n_i = 1'b0;

    counter_ctrl_if #(.COUNT_WIDTH(4), .PRESCALE_WIDTH(8)) bus ();

    counter_ctrl #(.COUNT_WIDTH(4), .PRESCALE_WIDTH(8)) dut (
        .clock_i   (clock_i),
        .reset_n_i (reset_n_i),
        .bus       (bus)
    );

    always #5 clock_i = ~clock_i;

    typedef enum int {M_IDLE, M_RUN, M_DONE} mode_t;

    int         checks = 0;
    int         errors = 0;
    mode_t      m_mode;
    logic       m_en;
    logic       m_clr;
    logic [7:0] m_p;
    logic       m_m;
    int         m_wait;
    logic [3:0] cv;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE;
        m_en   = 1'b0;
        m_clr  = 1'b0;
        m_p    = 8'd0;
        m_m    = 1'b0;
        m_wait = 0;
        cv     = 4'd0;
    endtask

    // One clock edge of the behavioural model; the emulated counter counts on the pre-edge enable.
    task automatic model_edge(input logic st, sp, stp, clr, os, input logic [7:0] pre);
        logic [3:0] cv_next;
        logic       en_next;
        cv_next = m_clr ? 4'd0 : (m_en ? cv + 4'd1 : cv);
        en_next = 1'b0;
        if (clr) begin
            m_mode = M_IDLE;
        end else if (sp) begin
            if (m_mode == M_RUN) m_mode = M_IDLE;
        end else if (st && m_mode != M_RUN) begin
            m_mode = M_RUN;
            m_p    = pre;
            m_m    = os;
            m_wait = int'(pre) + 1;
        end else if (m_mode == M_RUN) begin
            if (m_m && m_en && cv == 4'd15) begin
                m_mode = M_DONE;
            end else begin
                m_wait = m_wait - 1;
                if (m_wait == 0) begin
                    en_next = 1'b1;
                    m_wait  = int'(m_p) + 1;
                end
            end
        end else if (stp && m_mode == M_IDLE) begin
            en_next = 1'b1;
        end
        m_clr = clr;
        m_en  = en_next;
        cv    = cv_next;
    endtask

    task automatic cyc(input logic st, sp, stp, clr, os, input logic [7:0] pre);
        bus.start_i         = st;
        bus.stop_i          = sp;
        bus.step_i          = stp;
        bus.clear_i         = clr;
        bus.oneshot_i       = os;
        bus.prescale_i      = pre;
        bus.counter_value_i = cv;
        @(posedge clock_i);
        model_edge(st, sp, stp, clr, os, pre);
        #1;
        check("enable", 32'(bus.enable_o), 32'(m_en));
        check("clear",  32'(bus.clear_o),  32'(m_clr));
        check("busy",   32'(bus.busy_o),   32'(m_mode == M_RUN));
        check("done",   32'(bus.done_o),   32'(m_mode == M_DONE));
    endtask

    task automatic nop();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic do_reset();
        bus.start_i = 1'b0; bus.stop_i = 1'b0; bus.step_i = 1'b0;
        bus.clear_i = 1'b0; bus.oneshot_i = 1'b0; bus.prescale_i = 8'd0;
        bus.counter_value_i = 4'd0;
        reset_n_i = 1'b0;
        model_reset();
        @(negedge clock_i);
        reset_n_i = 1'b1;
        check("rst_enable", 32'(bus.enable_o), 32'd0);
        check("rst_clear",  32'(bus.clear_o),  32'd0);
        check("rst_busy",   32'(bus.busy_o),   32'd0);
        check("rst_done",   32'(bus.done_o),   32'd0);
    endtask

    initial begin
        int  n_en;
        bit  got;
        do_reset();

        // P=3 free-run: pulses after edges 4, 8, 12 only
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3);
        for (int i = 1; i <= 12; i++) begin
            nop();
            check("p3_enable", 32'(bus.enable_o), 32'(i % 4 == 0));
            check("p3_busy",   32'(bus.busy_o),   32'd1);
        end

        // P=0 oneshot from counter 0: 16 enables then DONE
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
        n_en = 0;
        got  = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            nop();
            if (bus.enable_o) n_en++;
            if (bus.done_o) got = 1'b1;
        end
        check("os_done_reached", 32'(got), 32'd1);
        check("os_enable_count", 32'(n_en), 32'd16);
        check("os_enable_off",   32'(bus.enable_o), 32'd0);

        // clear beats start in DONE
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        check("clr_pulse",  32'(bus.clear_o), 32'd1);
        check("clr_done",   32'(bus.done_o),  32'd0);
        check("clr_busy",   32'(bus.busy_o),  32'd0);
        nop();
        check("clr_pulse_end", 32'(bus.clear_o), 32'd0);

        // stop on the prescaler match edge suppresses the pulse
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2);
        nop();
        nop();
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        check("stop_enable", 32'(bus.enable_o), 32'd0);
        check("stop_busy",   32'(bus.busy_o),   32'd0);

        // step in IDLE pulses every cycle, ignored in RUN
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
            check("step_idle_enable", 32'(bus.enable_o), 32'd1);
        end
        nop();
        check("step_release", 32'(bus.enable_o), 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd4);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
            check("step_run_enable", 32'(bus.enable_o), 32'd0);
        end
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);

        // async reset mid-RUN while enable is high
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        nop();
        check("arst_pre_enable", 32'(bus.enable_o), 32'd1);
        #2;
        reset_n_i = 1'b0;
        #1;
        check("arst_enable", 32'(bus.enable_o), 32'd0);
        check("arst_clear",  32'(bus.clear_o),  32'd0);
        check("arst_busy",   32'(bus.busy_o),   32'd0);
        check("arst_done",   32'(bus.done_o),   32'd0);
        model_reset();
        #2;
        reset_n_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc(i == 0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
        end

        // randomized phase
        for (int i = 0; i < 4000; i++) begin
            cyc($urandom_range(0, 9) == 0,
                $urandom_range(0, 39) == 0,
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 59) == 0,
                $urandom_range(0, 1) == 1,
                8'($urandom_range(0, 5)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter_ctrl.md
COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 Parameter COUNT_WIDTH, default 4, width of the controlled counter value.
REQ-002 Parameter PRESCALE_WIDTH, default 8, width of the prescaler reload and internal prescaler.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low, and the ports are named clock_i and reset_n_i.
REQ-004 clock_i  in  1  rising-edge system clock.
REQ-005 reset_n_i  in  1  asynchronous active-low reset.
REQ-006 start_i  in  1  level-sampled start request.
REQ-007 stop_i  in  1  level-sampled stop request.
REQ-008 step_i  in  1  single enable pulse request, honoured in IDLE only.
REQ-009 clear_i  in  1  clear request.
REQ-010 oneshot_i  in  1  mode: 1 = stop after counter wrap, 0 = free-run.
REQ-011 prescale_i  in  PRESCALE_WIDTH  reload P; enable period = P+1 cycles.
REQ-012 counter_value_i  in  COUNT_WIDTH  current value of the controlled counter.
REQ-013 enable_o  out  1  registered enable to the counter.
REQ-014 clear_o  out  1  registered one-cycle clear pulse to the counter.
REQ-015 busy_o  out  1  high while state is RUN.
REQ-016 done_o  out  1  high while state is DONE.

Function
REQ-017 FSM states SHALL be IDLE, RUN and DONE, registered.
REQ-018 Per-edge input priority SHALL be clear_i > stop_i > start_i > step_i.
REQ-019 clear_i at edge k SHALL force IDLE, drive clear_o=1 after edge k for exactly one cycle, and drive enable_o=0 and done_o=0 after edge k.
REQ-020 IDLE + start_i at edge k SHALL enter RUN, clear the prescaler to 0, and latch prescale_i and oneshot_i as P and M.
REQ-021 In RUN the prescaler SHALL increment each cycle and reload to 0 when it equals P, and that edge SHALL set enable_o=1 for one cycle.
REQ-022 The first enable_o pulse SHALL follow edge k+1+P, with subsequent pulses every P+1 cycles; P=0 SHALL give enable_o continuously high.
REQ-023 Changes to prescale_i or oneshot_i during RUN SHALL have no effect until the next start.
REQ-024 stop_i in RUN at edge k SHALL enter IDLE, and enable_o SHALL be 0 after edge k even if the prescaler matched at edge k.
REQ-025 start_i in RUN SHALL be ignored.
REQ-026 In RUN with M=1, an edge where enable_o=1 and counter_value_i equals all-ones SHALL enter DONE.
REQ-027 On entering DONE, enable_o SHALL be 0 and done_o=1 from the following cycle.
REQ-028 With M=0 the block SHALL never enter DONE, and the counter wraps freely.
REQ-029 DONE SHALL hold until clear_i (to IDLE) or start_i.
REQ-030 start_i in DONE SHALL enter RUN exactly as from IDLE, with done_o low after that edge.
REQ-031 step_i in IDLE, with no higher-priority input, SHALL drive enable_o=1 for exactly one cycle after the edge, and the state SHALL remain IDLE.
REQ-032 step_i held high SHALL give one pulse per cycle.
REQ-033 step_i SHALL be ignored in RUN and DONE.
REQ-034 All outputs SHALL be registered with no combinational input-to-output path.

Reset
REQ-035 reset_n_i low SHALL immediately force state IDLE, prescaler 0, P=0, M=0, and enable_o=clear_o=busy_o=done_o=0, regardless of clock.
REQ-036 Deassertion of reset_n_i mid-RUN followed by start_i SHALL behave as a fresh start.

Structure
REQ-037 FSM state encoding and default width constants SHALL live in shared package counter_pkg.
REQ-038 The prescaler (count, reload compare, tick output) SHALL be sub-module counter_ctrl_prescaler, instantiated once.
REQ-039 counter_ctrl SHALL connect to the counter's enable input via enable_o, with clear_o ORed into its reset at board level.

Verification
REQ-040 Reset, then P=3, M=0, start_i pulse at edge 0 -> enable_o high after edges 4, 8, 12 only; busy_o=1.
REQ-041 P=0, M=1, counter at 0, start -> enable_o high 16 consecutive cycles; the edge with counter_value_i=15 enters DONE; done_o=1, enable_o=0.
REQ-042 RUN with stop_i on a prescaler-match edge -> no enable_o pulse; busy_o=0 next cycle.
REQ-043 clear_i and start_i on the same edge in DONE -> IDLE, clear_o one cycle, done_o=0, busy_o=0.
REQ-044 IDLE, step_i high for 3 cycles -> enable_o high for exactly 3 cycles; step_i in RUN -> no extra pulse.
REQ-045 reset_n_i low asynchronously mid-RUN with enable_o=1 -> all outputs 0 before the next clock edge.
